// File: rtl/dmem_stall.sv
// dmem_stall: DEPTH x 32-bit data memory with a programmable access latency.
// The MEM stage is frozen through stall until the one-cycle done pulse.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word accesses are trapped. When it is undefined, they are force-aligned.
module dmem_stall #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        done,
  output logic        misalign
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  // With LATENCY=1 there are no BUSY cycles: the access happens on the accept edge.
  localparam bit          FAST = (LATENCY == 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   counter;
  logic            l_we, l_uns;
  logic [1:0]      l_size;
  logic [AW+1:0]   l_addr;
  logic [31:0]     l_wdata;
  logic [31:0]     mem [DEPTH];

  logic            acc_we, acc_uns, do_access, misal;
  logic [1:0]      acc_size, lane;
  logic [AW+1:0]   acc_addr;
  logic [31:0]     acc_wdata, old_word, new_word, load_val;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. BUSY counts the latched counter down to 1.
  // The access is then performed on the edge that leaves BUSY.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req) state_nxt = FAST ? S_DONE : S_BUSY;
      S_BUSY: if (counter == CW'(1)) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: the stall signal is driven combinationally.
  always_comb begin
    stall = 1'b0;
    case (state)
      S_IDLE:  stall = req;
      S_BUSY:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Request latch and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      l_we    <= 1'b0;
      l_uns   <= 1'b0;
      l_size  <= 2'b00;
      l_addr  <= '0;
      l_wdata <= '0;
    end else if (state == S_IDLE && req) begin
      counter <= CW'(LATENCY - 1);
      l_we    <= memwrite;
      l_uns   <= unsigned_ld;
      l_size  <= size;
      l_addr  <= dataadr[AW+1:0];
      l_wdata <= writedata;
    end else if (state == S_BUSY && counter != CW'(1)) begin
      counter <= counter - CW'(1);
    end
  end

  // Access operands are live inputs on the accept edge and the latched copy afterwards.
  always_comb begin
    acc_we    = (state == S_IDLE) ? memwrite         : l_we;
    acc_uns   = (state == S_IDLE) ? unsigned_ld      : l_uns;
    acc_size  = (state == S_IDLE) ? size             : l_size;
    acc_addr  = (state == S_IDLE) ? dataadr[AW+1:0]  : l_addr;
    acc_wdata = (state == S_IDLE) ? writedata        : l_wdata;
    do_access = !reset && ((state == S_IDLE && req && FAST) ||
                           (state == S_BUSY && counter == CW'(1)));
  end

  // Lane selection, alignment handling, load extension and store merge.
  always_comb begin
`ifdef DMEM_MISALIGN_TRAP_EN
    misal = (acc_size == 2'b01 && acc_addr[0]) ||
            (acc_size[1] && acc_addr[1:0] != 2'b00);
    lane  = acc_addr[1:0];
`else
    misal = 1'b0;
    case (acc_size)
      2'b00:   lane = acc_addr[1:0];
      2'b01:   lane = {acc_addr[1], 1'b0};
      default: lane = 2'b00;
    endcase
`endif
    old_word = mem[acc_addr[AW+1:2]];
    ld_byte  = old_word[{lane, 3'b000} +: 8];
    ld_half  = old_word[{lane[1], 4'b0000} +: 16];
    new_word = old_word;
    case (acc_size)
      2'b00: begin
        load_val = {{24{~acc_uns & ld_byte[7]}}, ld_byte};
        new_word[{lane, 3'b000} +: 8] = acc_wdata[7:0];
      end
      2'b01: begin
        load_val = {{16{~acc_uns & ld_half[15]}}, ld_half};
        new_word[{lane[1], 4'b0000} +: 16] = acc_wdata[15:0];
      end
      default: begin
        load_val = old_word;
        new_word = acc_wdata;
      end
    endcase
  end

  // Storage write. A trapped store, or one cut off by reset, never commits.
  always_ff @(posedge clk) begin
    if (do_access && acc_we && !misal) mem[acc_addr[AW+1:2]] <= new_word;
  end

  // Registered completion outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      done     <= 1'b0;
      misalign <= 1'b0;
      readdata <= '0;
    end else begin
      done     <= do_access;
      misalign <= do_access && misal;
      if (do_access) readdata <= (acc_we || misal) ? 32'h0 : load_val;
    end
  end

endmodule

// File: tb/tb_dmem_stall.sv
// Self-checking bench for dmem_stall. It uses a LATENCY=2 instance and a LATENCY=1 instance.
module tb_dmem_stall;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, memwrite, unsigned_ld;
  logic [1:0]  size;
  logic [31:0] dataadr, writedata, readdata;
  logic        stall, done, misalign;
  logic        req1, memwrite1, unsigned_ld1;
  logic [1:0]  size1;
  logic [31:0] dataadr1, writedata1, readdata1;
  logic        stall1, done1, misalign1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  dmem_stall #(.DEPTH(64), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req(req), .memwrite(memwrite), .size(size),
    .unsigned_ld(unsigned_ld), .dataadr(dataadr), .writedata(writedata),
    .readdata(readdata), .stall(stall), .done(done), .misalign(misalign));

  dmem_stall #(.DEPTH(64), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .memwrite(memwrite1), .size(size1),
    .unsigned_ld(unsigned_ld1), .dataadr(dataadr1), .writedata(writedata1),
    .readdata(readdata1), .stall(stall1), .done(done1), .misalign(misalign1));

  // One access on the LATENCY=2 instance. Inputs are scrambled while BUSY.
  task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_mis, input string name);
    exp_t e;
    int   k;
    bit   seen;
    @(negedge clk);
    req = 1'b1; memwrite = we; size = sz; unsigned_ld = uns; dataadr = addr; writedata = wd;
    e.rd = exp_rd; e.mis = exp_mis;
    sb.push_back(e);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL %s stall_at_req got %b exp 1", name, stall);
    end
    k = 0; seen = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) seen = 1;
      else begin
        checks++;
        if (stall !== 1'b1) begin
          errors++; $display("FAIL %s stall_busy cycle %0d got %b exp 1", name, k, stall);
        end
        memwrite = ~we; size = 2'($urandom); dataadr = $urandom; writedata = $urandom;
      end
    end
    checks++;
    if (!seen || k != LAT) begin
      errors++; $display("FAIL %s latency got %0d (seen %0d) exp %0d", name, k, seen, LAT);
    end
    e = sb.pop_front();
    if (seen) begin
      checks++;
      if (readdata !== e.rd) begin
        errors++; $display("FAIL %s readdata got %h exp %h", name, readdata, e.rd);
      end
      checks++;
      if (misalign !== e.mis) begin
        errors++; $display("FAIL %s misalign got %b exp %b", name, misalign, e.mis);
      end
      checks++;
      if (stall !== 1'b0) begin
        errors++; $display("FAIL %s stall_at_done got %b exp 0", name, stall);
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req = 1'b0; memwrite = 1'b0; size = 2'b10; unsigned_ld = 1'b0; dataadr = '0; writedata = '0;
    req1 = 1'b0; memwrite1 = 1'b0; size1 = 2'b10; unsigned_ld1 = 1'b0; dataadr1 = '0; writedata1 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({readdata, done, misalign, stall} !== 35'h0) begin
      errors++; $display("FAIL reset_state got rd=%h done=%b mis=%b stall=%b exp all 0",
                         readdata, done, misalign, stall);
    end
    checks++;
    if ({readdata1, done1, misalign1, stall1} !== 35'h0) begin
      errors++; $display("FAIL reset_state_l1 got rd=%h done=%b mis=%b stall=%b exp all 0",
                         readdata1, done1, misalign1, stall1);
    end
    reset = 1'b0;
  endtask

  task automatic test_word;
    access(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 32'h0, 1'b0, "sw_20");
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, "lw_20");
  endtask

  task automatic test_byte;
    access(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFAB, 32'h0, 1'b0, "sb_21");
    access(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h000000AB, 1'b0, "lbu_21");
    access(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'hFFFFFFAB, 1'b0, "lb_21");
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1234AB78, 1'b0, "lw_20_after_sb");
  endtask

  task automatic test_half;
    access(1'b1, 2'b01, 1'b0, 32'h22, 32'h77778001, 32'h0, 1'b0, "sh_22");
    access(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, "lh_22");
    access(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h00008001, 1'b0, "lhu_22");
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h8001AB78, 1'b0, "lw_20_after_sh");
  endtask

  task automatic test_alias;
    access(1'b1, 2'b10, 1'b0, 32'h100, 32'h00000055, 32'h0, 1'b0, "sw_100");
    access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h00000055, 1'b0, "lw_0_alias");
  endtask

  task automatic test_misalign;
`ifdef DMEM_MISALIGN_TRAP_EN
    access(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1, "lw_22_trap");
    access(1'b1, 2'b11, 1'b0, 32'h23, 32'hCAFEF00D, 32'h0, 1'b1, "sw_23_trap");
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h8001AB78, 1'b0, "lw_20_unchanged");
`else
    access(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h8001AB78, 1'b0, "lw_22_aligned");
    access(1'b1, 2'b11, 1'b0, 32'h23, 32'hCAFEF00D, 32'h0, 1'b0, "sw_23_aligned");
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "lw_20_after_sw23");
`endif
  endtask

  task automatic test_reset_abort;
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'h11111111, 32'h0, 1'b0, "sw_10_old");
    @(negedge clk);
    req = 1'b1; memwrite = 1'b1; size = 2'b10; dataadr = 32'h10; writedata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL abort_busy stall got %b exp 1", stall);
    end
    reset = 1'b1;
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL abort_done_in_reset got %b exp 0", done);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || stall !== 1'b0) begin
        errors++; $display("FAIL abort_idle got done=%b stall=%b exp 0 0", done, stall);
      end
    end
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11111111, 1'b0, "lw_10_not_committed");
  endtask

  task automatic test_latency1;
    @(negedge clk);
    req1 = 1'b1; memwrite1 = 1'b1; size1 = 2'b10; dataadr1 = 32'h8; writedata1 = 32'hA5A5A5A5;
    #1;
    checks++;
    if (stall1 !== 1'b1) begin
      errors++; $display("FAIL l1_sw stall got %b exp 1", stall1);
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b1 || stall1 !== 1'b0 || readdata1 !== 32'h0) begin
      errors++; $display("FAIL l1_sw_done got done=%b stall=%b rd=%h exp 1 0 0", done1, stall1, readdata1);
    end
    req1 = 1'b0;
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0) begin
      errors++; $display("FAIL l1_pulse got %b exp 0", done1);
    end
    req1 = 1'b1; memwrite1 = 1'b0; dataadr1 = 32'h8;
    @(negedge clk);
    checks++;
    if (done1 !== 1'b1 || readdata1 !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL l1_lw got done=%b rd=%h exp 1 a5a5a5a5", done1, readdata1);
    end
    req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_alias();
    test_misalign();
    test_reset_abort();
    test_latency1();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
